quad_enc_gen: RTL and testbench

QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

---
 rtl/quad_enc_gen.sv | 129 ++++++++++++
 tb/tb_quad_enc_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_gen.sv
// quad_enc_gen: command-driven quadrature encoder pattern generator.
//
// A command (direction, number of edges, clk cycles between edges) is
// accepted in IDLE. In RUN the block emits one quadrature transition every
// P cycles on enc_a/enc_b and tracks a signed edge position in pos. The
// quadrature phase and pos persist across commands; only reset clears them.
//
// Handshake: a command transfers on a posedge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE and out of reset. cmd_valid
// seen while busy is dropped, never queued. Command fields are sampled only
// at the transfer edge.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_dir           1 = forward (A leads B), 0 = reverse
//   cmd_steps         number of quadrature edges to emit
//   cmd_period        clk cycles between edges (0 behaves as 1)
//   abort             stop the active command, no further edge, no done
//   enc_a, enc_b      registered quadrature outputs
//   busy              command in progress
//   done              one-cycle pulse after the final edge of a command
//   pos               two's complement edge position, wraps
//   state_dbg         current FSM state (0 = IDLE, 1 = RUN)
module quad_enc_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ONE_D = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             dir_q;
  logic [CNT_W-1:0] steps_left;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] tick_cnt;

  logic [DIV_W-1:0] p_eff;
  logic             accept;
  logic             fire;
  logic             last;
  logic [1:0]       phase;
  logic [1:0]       phase_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and combinational controls.
  always_comb begin
    state_nxt = state;
    p_eff     = (cmd_period == '0) ? ONE_D : cmd_period;
    accept    = (state == IDLE) && cmd_valid;
    // abort wins over a scheduled edge, including the last one.
    fire      = (state == RUN) && !abort && (tick_cnt == '0);
    last      = fire && (steps_left == ONE_C);
    // Gray position index: 00->0, 10->1, 11->2, 01->3. Forward is +1.
    phase     = {enc_b, enc_a ^ enc_b};
    phase_nxt = dir_q ? (phase + 2'd1) : (phase - 2'd1);
    unique case (state)
      IDLE: if (accept && (cmd_steps != '0)) state_nxt = RUN;
      RUN:  if (abort || last)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state == RUN) && !rst;
  assign state_dbg = state;

  // Datapath. tick_cnt counts down to the next edge; loading P-1 at
  // acceptance places the first edge P cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_a      <= 1'b0;
      enc_b      <= 1'b0;
      pos        <= '0;
      done       <= 1'b0;
      dir_q      <= 1'b0;
      steps_left <= '0;
      period_q   <= ONE_D;
      tick_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dir_q      <= cmd_dir;
        steps_left <= cmd_steps;
        period_q   <= p_eff;
        tick_cnt   <= p_eff - ONE_D;
        // A zero-step command completes immediately without leaving IDLE.
        if (cmd_steps == '0) done <= 1'b1;
      end else if (fire) begin
        enc_a      <= phase_nxt[1] ^ phase_nxt[0];
        enc_b      <= phase_nxt[1];
        pos        <= dir_q ? (pos + ONE_C) : (pos - ONE_C);
        steps_left <= steps_left - ONE_C;
        tick_cnt   <= period_q - ONE_D;
        if (last) done <= 1'b1;
      end else if ((state == RUN) && !abort) begin
        tick_cnt <= tick_cnt - ONE_D;
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Testbench for quad_enc_gen. A behavioural model tracks the command schedule
// (edge k of a command lands k*P cycles after acceptance), the quadrature
// position as an index into the forward sequence table, and pos as plain
// arithmetic. Each test task compares the DUT against the model and fixed
// values from the directed scenarios.
module tb_quad_enc_gen;
  localparam int CNT_W = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic             enc_a;
  logic             enc_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pos;
  logic             state_dbg;

  quad_enc_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done),
    .pos(pos), .state_dbg(state_dbg)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  longint cyc;

  // Forward quadrature sequence; reverse walks it backwards.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Model state.
  int               m_idx;
  logic [CNT_W-1:0] m_pos;
  logic             m_done;
  logic             m_active;
  longint           m_t0;
  int               m_p;
  int               m_n;
  int               m_edges;
  logic             m_dir;
  logic [1:0]       exp_q[$];

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_idx = 0; m_pos = '0; exp_q.delete();
    end else if (!m_active) begin
      if (cmd_valid) begin
        if (cmd_steps == '0) m_done = 1'b1;
        else begin
          m_active = 1'b1; m_t0 = cyc; m_edges = 0;
          m_p = (cmd_period == '0) ? 1 : int'(cmd_period);
          m_n = int'(cmd_steps); m_dir = cmd_dir;
          for (int i = 1; i <= m_n; i++)
            exp_q.push_back(seq[(m_idx + i * (m_dir ? 1 : 3)) % 4]);
        end
      end
    end else if (abort) begin
      m_active = 1'b0; exp_q.delete();
    end else if (((cyc - m_t0) % longint'(m_p)) == 0) begin
      m_idx = m_dir ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
      m_pos = m_dir ? m_pos + 1'b1 : m_pos - 1'b1;
      m_edges++;
      if (m_edges == m_n) begin m_active = 1'b0; m_done = 1'b1; end
    end
    #1;
  endtask

  // Driver: present a command for one edge, then scramble the fields.
  task automatic send(input logic dir, input int steps, input int period);
    cmd_valid = 1'b1; cmd_dir = dir;
    cmd_steps = CNT_W'(steps); cmd_period = DIV_W'(period);
    tick();
    cmd_valid = 1'b0;
    cmd_dir = 1'($urandom); cmd_steps = CNT_W'($urandom); cmd_period = DIV_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
    repeat (3) tick();
    vectors++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || {enc_a, enc_b} !== 2'b00 || pos !== '0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold got rdy=%b busy=%b ab=%b pos=%h done=%b want 0 0 00 0000 0",
               cmd_ready, busy, {enc_a, enc_b}, pos, done);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_fwd();
    int done_at;
    int done_n;
    logic [1:0] want [13];
    want[3] = 2'b10; want[6] = 2'b11; want[9] = 2'b01; want[12] = 2'b00;
    done_at = -1; done_n = 0;
    send(1'b1, 4, 3);
    for (int k = 1; k <= 14; k++) begin
      tick();
      vectors++;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done || cmd_ready !== (!m_active)) begin
        miscompares++;
        $display("FAIL fwd k=%0d got ab=%b pos=%h done=%b rdy=%b want ab=%b pos=%h done=%b rdy=%b",
                 k, {enc_a, enc_b}, pos, done, cmd_ready, seq[m_idx], m_pos, m_done, !m_active);
      end
      if (k % 3 == 0 && k <= 12) begin
        vectors++;
        if ({enc_a, enc_b} !== want[k]) begin
          miscompares++;
          $display("FAIL fwd_ab k=%0d got %b want %b", k, {enc_a, enc_b}, want[k]);
        end
      end
      if (done === 1'b1) begin done_at = k; done_n++; end
    end
    vectors++;
    if (pos !== 16'd4 || done_at != 12 || done_n != 1) begin
      miscompares++;
      $display("FAIL fwd_end got pos=%h done_at=%0d pulses=%0d want pos=0004 done_at=12 pulses=1",
               pos, done_at, done_n);
    end
  endtask

  task automatic test_rev();
    int done_n;
    logic [1:0] want [5];
    want = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    done_n = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    send(1'b0, 5, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done || cmd_ready !== (!m_active)) begin
        miscompares++;
        $display("FAIL rev k=%0d got ab=%b pos=%h done=%b rdy=%b want ab=%b pos=%h done=%b rdy=%b",
                 k, {enc_a, enc_b}, pos, done, cmd_ready, seq[m_idx], m_pos, m_done, !m_active);
      end
      if (k <= 5) begin
        vectors++;
        if ({enc_a, enc_b} !== want[k-1]) begin
          miscompares++;
          $display("FAIL rev_ab k=%0d got %b want %b", k, {enc_a, enc_b}, want[k-1]);
        end
      end
      if (done === 1'b1) done_n++;
    end
    vectors++;
    if (pos !== 16'hFFFB || done_n != 1) begin
      miscompares++;
      $display("FAIL rev_end got pos=%h pulses=%0d want pos=fffb pulses=1", pos, done_n);
    end
  endtask

  task automatic test_period_zero();
    logic [1:0] ab0;
    send(1'b1, 2, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done || cmd_ready !== (!m_active)) begin
        miscompares++;
        $display("FAIL p0 k=%0d got ab=%b pos=%h done=%b rdy=%b want ab=%b pos=%h done=%b rdy=%b",
                 k, {enc_a, enc_b}, pos, done, cmd_ready, seq[m_idx], m_pos, m_done, !m_active);
      end
    end
    vectors++;
    if (pos !== 16'hFFFD) begin
      miscompares++;
      $display("FAIL p0_pos got %h want fffd", pos);
    end
    ab0 = {enc_a, enc_b};
    send(1'b1, 0, 7);
    vectors++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || {enc_a, enc_b} !== ab0) begin
      miscompares++;
      $display("FAIL zero_steps got done=%b rdy=%b busy=%b ab=%b want 1 1 0 %b",
               done, cmd_ready, busy, {enc_a, enc_b}, ab0);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || {enc_a, enc_b} !== ab0) begin
      miscompares++;
      $display("FAIL zero_steps_after got done=%b rdy=%b ab=%b want 0 1 %b", done, cmd_ready, {enc_a, enc_b}, ab0);
    end
  endtask

  task automatic test_abort();
    logic [CNT_W-1:0] pos0;
    int done_n;
    pos0 = pos; done_n = 0;
    send(1'b1, 10, 2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 5) abort = 1'b1;
      if (k == 6) abort = 1'b0;
      vectors++;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done || cmd_ready !== (!m_active)) begin
        miscompares++;
        $display("FAIL abort k=%0d got ab=%b pos=%h done=%b rdy=%b want ab=%b pos=%h done=%b rdy=%b",
                 k, {enc_a, enc_b}, pos, done, cmd_ready, seq[m_idx], m_pos, m_done, !m_active);
      end
      if (done === 1'b1) done_n++;
    end
    vectors++;
    if (pos !== pos0 + 16'd2 || done_n != 0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_end got pos=%h pulses=%0d rdy=%b want pos=%h pulses=0 rdy=1",
               pos, done_n, cmd_ready, pos0 + 16'd2);
    end
  endtask

  task automatic test_wrap_busy();
    int bad;
    bad = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    send(1'b1, 32767, 1);
    for (int k = 1; k <= 32770; k++) begin
      tick();
      if (k == 100) begin cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd3; cmd_period = 16'd1; end
      if (k == 101) cmd_valid = 1'b0;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done) bad++;
    end
    vectors++;
    if (bad != 0 || pos !== 16'h7FFF || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL long_run got bad_cycles=%0d pos=%h rdy=%b want 0 7fff 1", bad, pos, cmd_ready);
    end
    send(1'b1, 1, 5);
    repeat (5) tick();
    vectors++;
    if (pos !== 16'h8000 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap got pos=%h done=%b want 8000 1", pos, done);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    done_n = 0;
    send(1'b1, 4, 2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (done === 1'b1) done_n++;
      if (k == 3) rst = 1'b1;
    end
    vectors++;
    if ({enc_a, enc_b} !== 2'b00 || pos !== '0 || done !== 1'b0 || done_n != 0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got ab=%b pos=%h done=%b pulses=%0d rdy=%b busy=%b want 00 0000 0 0 0 0",
               {enc_a, enc_b}, pos, done, done_n, cmd_ready, busy);
    end
    rst = 1'b0;
    send(1'b0, 1, 1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_accept got busy=%b want 1", busy);
    end
    tick();
    vectors++;
    if ({enc_a, enc_b} !== 2'b01 || pos !== 16'hFFFF || done !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_next got ab=%b pos=%h done=%b want 01 ffff 1", {enc_a, enc_b}, pos, done);
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_ab;
    logic [1:0] e;
    exp_q.delete();
    prev_ab = {enc_a, enc_b};
    for (int c = 0; c < 1500; c++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_dir    = 1'($urandom);
      cmd_steps  = CNT_W'($urandom_range(0, 6));
      cmd_period = DIV_W'($urandom_range(0, 3));
      abort      = ($urandom_range(0, 19) == 0);
      tick();
      vectors++;
      if ({enc_a, enc_b} !== seq[m_idx] || pos !== m_pos || done !== m_done || cmd_ready !== (!m_active) || busy !== m_active) begin
        miscompares++;
        $display("FAIL rand c=%0d got ab=%b pos=%h done=%b rdy=%b busy=%b want ab=%b pos=%h done=%b rdy=%b busy=%b",
                 c, {enc_a, enc_b}, pos, done, cmd_ready, busy, seq[m_idx], m_pos, m_done, !m_active, m_active);
      end
      if ({enc_a, enc_b} !== prev_ab) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_sb c=%0d unexpected edge ab=%b", c, {enc_a, enc_b});
        end else begin
          e = exp_q.pop_front();
          if ({enc_a, enc_b} !== e) begin
            miscompares++;
            $display("FAIL rand_sb c=%0d got ab=%b want %b", c, {enc_a, enc_b}, e);
          end
        end
      end
      prev_ab = {enc_a, enc_b};
    end
    cmd_valid = 1'b0; abort = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    m_idx = 0; m_pos = '0; m_done = 1'b0; m_active = 1'b0;
    m_t0 = 0; m_p = 1; m_n = 0; m_edges = 0; m_dir = 1'b0;
    test_reset();
    test_fwd();
    test_rev();
    test_period_zero();
    test_abort();
    test_wrap_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
